// File: rtl/rapid_pkg.sv
// rapid_pkg: shared core definitions for the writeback path.
//   XLEN     - integer register width.
//   WB_NREQ  - default number of writeback requesters.
//   wb_req_s - one writeback request (valid, destination, data).
//   wb_src_e - writeback source indices as wired into the arbiter.
package rapid_pkg;

  localparam int XLEN    = 32;
  localparam int WB_NREQ = 3;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_s;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: picks one requester per cycle, one-hot grant.
//   i_req   [NREQ]  request vector.
//   i_ptr   [PW]    search start index (WB_ARB_RR_EN builds only).
//   o_grant [NREQ]  one-hot grant, zero when no request.
// Macro WB_ARB_RR_EN: defined -> round-robin starting at i_ptr;
// undefined -> fixed priority, lowest index wins (no pointer port).
module wb_rr_arbiter #(
  parameter int NREQ = 3
`ifdef WB_ARB_RR_EN
  ,
  parameter int PW = 2
`endif
) (
  input  logic [NREQ-1:0] i_req,
`ifdef WB_ARB_RR_EN
  input  logic [PW-1:0]   i_ptr,
`endif
  output logic [NREQ-1:0] o_grant
);

`ifdef WB_ARB_RR_EN
  logic [NREQ-1:0] mask_s;
  logic [NREQ-1:0] hi_s;
  logic [NREQ-1:0] pick_s;

  // Requests at or above the pointer take precedence; if none, wrap to the
  // full vector. x & (~x + 1) isolates the lowest set bit.
  always_comb begin
    mask_s  = ~((NREQ'(1) << i_ptr) - NREQ'(1));
    hi_s    = i_req & mask_s;
    pick_s  = (|hi_s) ? hi_s : i_req;
    o_grant = pick_s & (~pick_s + NREQ'(1));
  end
`else
  // Fixed priority: lowest set bit of the request vector.
  always_comb begin
    o_grant = i_req & (~i_req + NREQ'(1));
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NREQ
// writeback sources and tracks pending writes for issue hazard checks.
//   i_clk, i_reset           clock, async active-high reset.
//   i_flush                  clears scoreboard and output rd, blocks accept.
//   i_req_valid/rd/data      packed per-source writeback requests.
//   o_req_ready              one-hot accept (combinational).
//   i_issue_valid/rd         issuing instruction's destination (sets pend).
//   i_chk_rs1/rs2            sources to hazard-check.
//   o_rs1/rs2_pending        RAW indication (effective pending).
//   o_issue_stall            WAW indication for i_issue_rd.
//   o_rd/o_rd_data           registered write to register file (rd=0 idle).
// Macro WB_ARB_RR_EN selects round-robin arbitration; default is fixed
// priority with the lowest index winning.
module regfile_wb_arbiter
  import rapid_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int XLEN = rapid_pkg::XLEN
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*5-1:0]    i_req_rd,
  input  logic [NREQ*XLEN-1:0] i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic                 i_issue_valid,
  input  logic [4:0]           i_issue_rd,
  input  logic [4:0]           i_chk_rs1,
  input  logic [4:0]           i_chk_rs2,
  output logic                 o_rs1_pending,
  output logic                 o_rs2_pending,
  output logic                 o_issue_stall,
  output logic [4:0]           o_rd,
  output logic [XLEN-1:0]      o_rd_data
);

  logic [NREQ-1:0] grant_s;
  logic [NREQ-1:0] ready_s;
  logic            xfer_s;
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] data_r;
  logic [31:0]     pend_r;
  logic [31:0]     clr_vec_s;
  logic [31:0]     eff_pend_s;
  logic [31:0]     set_vec_s;
  logic            stall_s;

`ifdef WB_ARB_RR_EN
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] sel_idx_s;

  wb_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (ptr_r),
    .o_grant (grant_s)
  );
`else
  wb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (i_req_valid),
    .o_grant (grant_s)
  );
`endif

  // No acceptance while flushing or held in reset.
  assign ready_s     = grant_s & {NREQ{!i_flush && !i_reset}};
  assign xfer_s      = |ready_s;
  assign o_req_ready = ready_s;

  // Grant is one-hot, so OR-ing masked slices yields the winning request.
  always_comb begin
    sel_rd_s   = 5'd0;
    sel_data_s = '0;
`ifdef WB_ARB_RR_EN
    sel_idx_s  = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      sel_rd_s   = sel_rd_s | (i_req_rd[k*5 +: 5] & {5{ready_s[k]}});
      sel_data_s = sel_data_s | (i_req_data[k*XLEN +: XLEN] & {XLEN{ready_s[k]}});
`ifdef WB_ARB_RR_EN
      sel_idx_s  = sel_idx_s | (PW'(k) & {PW{ready_s[k]}});
`endif
    end
  end

  // Output write register; data holds on idle so only rd has to be cleared.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_r   <= 5'd0;
      data_r <= '0;
    end else if (i_flush) begin
      rd_r   <= 5'd0;
    end else if (xfer_s) begin
      rd_r   <= sel_rd_s;
      data_r <= sel_data_s;
    end else begin
      rd_r   <= 5'd0;
    end
  end

`ifdef WB_ARB_RR_EN
  // Round-robin pointer: one past the last granted source; flush keeps it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= (sel_idx_s == PW'(NREQ - 1)) ? '0 : sel_idx_s + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // The register being written this cycle is treated as already clear,
  // because the register file forwards the write data on this cycle.
  always_comb begin
    clr_vec_s  = (32'd1 << rd_r) & {32{rd_r != 5'd0}};
    eff_pend_s = pend_r & ~clr_vec_s;
    stall_s    = eff_pend_s[i_issue_rd];
    set_vec_s  = (32'd1 << i_issue_rd)
               & {32{i_issue_valid && !stall_s && (i_issue_rd != 5'd0)}};
  end

  // Scoreboard: set wins over clear on the same register; x0 never pends.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend_r <= 32'd0;
    end else if (i_flush) begin
      pend_r <= 32'd0;
    end else begin
      pend_r <= ((pend_r & ~clr_vec_s) | set_vec_s) & ~32'd1;
    end
  end

  assign o_rs1_pending = eff_pend_s[i_chk_rs1];
  assign o_rs2_pending = eff_pend_s[i_chk_rs2];
  assign o_issue_stall = stall_s;
  assign o_rd          = rd_r;
  assign o_rd_data     = data_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus hand sequences
// for async reset and contention.
module tb_regfile_wb_arbiter;
  import rapid_pkg::*;

  localparam int N  = 3;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_rd;
  logic [N*XL-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            rs1_pending;
  logic            rs2_pending;
  logic            issue_stall;
  logic [4:0]      o_rd;
  logic [XL-1:0]   o_rd_data;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NREQ(N), .XLEN(XL)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_flush       (flush),
    .i_req_valid   (req_valid),
    .i_req_rd      (req_rd),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_chk_rs1     (chk_rs1),
    .i_chk_rs2     (chk_rs2),
    .o_rs1_pending (rs1_pending),
    .o_rs2_pending (rs2_pending),
    .o_issue_stall (issue_stall),
    .o_rd          (o_rd),
    .o_rd_data     (o_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  vld;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fl;
    logic [2:0]  e_rdy;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        chk_data;
    logic        e_p1;
    logic        e_p2;
    logic        e_stall;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic [2:0] vld, input logic [4:0] rd,
                              input logic [31:0] data, input logic iv,
                              input logic [4:0] ird, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic fl,
                              input logic [2:0] e_rdy, input logic [4:0] e_rd,
                              input logic [31:0] e_data, input logic cd,
                              input logic e_p1, input logic e_p2,
                              input logic e_stall);
    vec_t v;
    v.vld = vld; v.rd = rd; v.data = data; v.iv = iv; v.ird = ird;
    v.rs1 = rs1; v.rs2 = rs2; v.fl = fl; v.e_rdy = e_rdy; v.e_rd = e_rd;
    v.e_data = e_data; v.chk_data = cd; v.e_p1 = e_p1; v.e_p2 = e_p2;
    v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; req_valid = 3'b000; req_rd = 15'd0; req_data = 96'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
  endtask

  initial begin
    logic [2:0] exp_rdy;
    logic [4:0] exp_rd;
    logic [4:0] prev_rd;

    // vld rd data | iv ird rs1 rs2 fl || rdy o_rd o_data chk p1 p2 stall
    vecs[0]  = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 3'b000, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(3'b001, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 3'b001, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 3'b000, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 3'b000, 5'd0,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(3'b000, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7, 5'd0,  1'b0, 3'b000, 5'd0,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(3'b010, 5'd7,  32'h77,       1'b0, 5'd0, 5'd7, 5'd0,  1'b0, 3'b010, 5'd0,  32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7, 5'd0,  1'b0, 3'b000, 5'd7,  32'h77,       1'b1, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7, 5'd7,  1'b0, 3'b000, 5'd0,  32'h77,       1'b1, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(3'b000, 5'd0,  32'h0,        1'b1, 5'd9, 5'd0, 5'd0,  1'b0, 3'b000, 5'd0,  32'h77,       1'b1, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(3'b100, 5'd9,  32'h99,       1'b1, 5'd9, 5'd0, 5'd9,  1'b0, 3'b100, 5'd0,  32'h77,       1'b1, 1'b0, 1'b1, 1'b1);
    vecs[10] = mk(3'b000, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9, 5'd0,  1'b0, 3'b000, 5'd9,  32'h99,       1'b1, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd0,  1'b0, 3'b000, 5'd0,  32'h99,       1'b1, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(3'b001, 5'd0,  32'h1234,     1'b1, 5'd0, 5'd0, 5'd9,  1'b0, 3'b001, 5'd0,  32'h99,       1'b1, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd9,  1'b0, 3'b000, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(3'b001, 5'd9,  32'hA,        1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 3'b001, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd0,  1'b0, 3'b000, 5'd9,  32'hA,        1'b1, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd0,  1'b0, 3'b000, 5'd0,  32'hA,        1'b1, 1'b0, 1'b0, 1'b0);
    vecs[17] = mk(3'b000, 5'd0,  32'h0,        1'b1, 5'd3, 5'd0, 5'd0,  1'b0, 3'b000, 5'd0,  32'hA,        1'b1, 1'b0, 1'b0, 1'b0);
    vecs[18] = mk(3'b000, 5'd0,  32'h0,        1'b1, 5'd4, 5'd3, 5'd0,  1'b0, 3'b000, 5'd0,  32'hA,        1'b1, 1'b1, 1'b0, 1'b0);
    vecs[19] = mk(3'b001, 5'd12, 32'hC,        1'b0, 5'd0, 5'd3, 5'd4,  1'b0, 3'b001, 5'd0,  32'hA,        1'b1, 1'b1, 1'b1, 1'b0);
    vecs[20] = mk(3'b010, 5'd13, 32'hD,        1'b1, 5'd5, 5'd3, 5'd4,  1'b1, 3'b000, 5'd12, 32'hC,        1'b1, 1'b1, 1'b1, 1'b0);
    vecs[21] = mk(3'b000, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3, 5'd4,  1'b0, 3'b000, 5'd0,  32'hC,        1'b1, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(3'b000, 5'd0,  32'h0,        1'b1, 5'd4, 5'd5, 5'd12, 1'b0, 3'b000, 5'd0,  32'hC,        1'b1, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    // Table: drive, let combinational outputs settle, compare, advance.
    for (int i = 0; i < 23; i++) begin
      flush       = vecs[i].fl;
      req_valid   = vecs[i].vld;
      req_rd      = {3{vecs[i].rd}};
      req_data    = {3{vecs[i].data}};
      issue_valid = vecs[i].iv;
      issue_rd    = vecs[i].ird;
      chk_rs1     = vecs[i].rs1;
      chk_rs2     = vecs[i].rs2;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d_rd", i), 32'(o_rd), 32'(vecs[i].e_rd));
      if (vecs[i].chk_data) begin
        chk($sformatf("row%0d_data", i), o_rd_data, vecs[i].e_data);
      end else begin
      end
      chk($sformatf("row%0d_rs1_pend", i), 32'(rs1_pending), 32'(vecs[i].e_p1));
      chk($sformatf("row%0d_rs2_pend", i), 32'(rs2_pending), 32'(vecs[i].e_p2));
      chk($sformatf("row%0d_stall", i), 32'(issue_stall), 32'(vecs[i].e_stall));
      step();
    end

    // Async reset in the middle of a cycle with a write in flight.
    idle_inputs();
    req_valid = 3'b001; req_rd = {3{5'd8}}; req_data = {3{32'h88}};
    issue_valid = 1'b1; issue_rd = 5'd6;
    step();
    issue_valid = 1'b0; issue_rd = 5'd0; chk_rs1 = 5'd6;
    #1;
    chk("prerst_rd", 32'(o_rd), 32'd8);
    chk("prerst_data", o_rd_data, 32'h88);
    chk("prerst_rs1_pend", 32'(rs1_pending), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_data", o_rd_data, 32'h0);
    chk("rst_rs1_pend", 32'(rs1_pending), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk_rs1 = 5'd4;
    #1;
    chk("rst_pend4", 32'(rs1_pending), 32'd0);
    step();
    idle_inputs();
    rst = 1'b0;

    // Contention: all three sources valid for six cycles.
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    prev_rd   = 5'd0;
    for (int c = 0; c < 6; c++) begin
`ifdef WB_ARB_RR_EN
      exp_rdy = 3'b001 << (c % 3);
      exp_rd  = 5'((c % 3) + 1);
`else
      exp_rdy = 3'b001;
      exp_rd  = 5'd1;
`endif
      #1;
      chk($sformatf("cont%0d_ready", c), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("cont%0d_rd", c), 32'(o_rd), 32'(prev_rd));
      prev_rd = exp_rd;
      step();
    end
    idle_inputs();
    #1;
    chk("cont_last_rd", 32'(o_rd), 32'(prev_rd));
    chk("cont_last_data", o_rd_data, 32'(prev_rd) * 32'h11);
    step();
    chk("cont_idle_rd", 32'(o_rd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
